// File: rtl/prbs7_checker_64.sv
`default_nettype none
// ============================================================================
//  Module   : prbs7_checker_64
//  Purpose  : Self-synchronising PRBS-7 (x^7+x^6+1) checker for a 64-bit
//             aligned word stream. Each bit is predicted from the 7 and 6
//             bits before it in serial order, so no seed alignment is needed.
//             Provides lock FSM, per-word error flag / bit count and
//             saturating bit-error and word counters for BER measurement.
//  Ports    : clk      - word clock
//             rst_n    - asynchronous active-low reset
//             din      - aligned data word, bit 0 = earliest serial bit
//             en       - word qualifier (0 = word ignored)
//             clr_cnt  - synchronous clear of err_cnt / word_cnt
//             locked   - FSM is in LOCKED
//             err_flag - current checked word had at least one bit error
//             err_bits - number of bit errors in current checked word
//             err_cnt  - saturating bit-error total (counted while LOCKED)
//             word_cnt - saturating checked-word total (counted while LOCKED)
//  Revision : 1.0 - initial release
// ============================================================================
module prbs7_checker_64 #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [6:0]       err_bits,
  output logic [CNT_W-1:0] err_cnt,
  output logic [47:0]      word_cnt
);

  localparam int c_RUN_W = $clog2(LOCK_CNT + 1);
  localparam int c_BAD_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Stage 1: accepted word and the tail of the word before it. Only the top
  // seven bits of the previous word feed the prediction of bits 0..6.
  logic        r_primed;
  logic [6:0]  r_last_tail;
  logic [6:0]  r_prv_tail;
  logic [63:0] r_cur;
  logic        r_v1;

  // Stage 2 valid (err_flag / err_bits hold the result)
  logic        r_v2;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_RUN_W-1:0]   r_run;
  logic [c_RUN_W-1:0]   w_run_nxt;
  logic [c_BAD_W-1:0]   r_bad;
  logic [c_BAD_W-1:0]   w_bad_nxt;

  logic [63:0]          w_pred;
  logic [63:0]          w_ev;
  logic [6:0]           w_pop;
  logic [CNT_W:0]       w_err_sum;

  // The first accepted word after reset only seeds the previous-word tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed    <= 1'b0;
      r_last_tail <= '0;
      r_prv_tail  <= '0;
      r_cur       <= '0;
      r_v1        <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (en) begin
        r_primed    <= 1'b1;
        r_last_tail <= din[63:57];
        if (r_primed) begin
          r_cur      <= din;
          r_prv_tail <= r_last_tail;
          r_v1       <= 1'b1;
        end
      end
    end
  end

  // r_prv_tail[k] holds previous-word bit 57+k.
  always_comb begin
    w_pred = '0;
    for (int n = 7; n < 64; n++) begin
      w_pred[n] = r_cur[n-7] ^ r_cur[n-6];
    end
    for (int n = 0; n < 6; n++) begin
      w_pred[n] = r_prv_tail[n] ^ r_prv_tail[n+1];
    end
    w_pred[6] = r_prv_tail[6] ^ r_cur[0];
    // An all-zero word satisfies the recurrence trivially; flag it as fully
    // errored so a dead link can never lock.
    w_ev = (r_cur == 64'd0) ? {64{1'b1}} : (r_cur ^ w_pred);
    w_pop = '0;
    for (int i = 0; i < 64; i++) begin
      w_pop = w_pop + {6'd0, w_ev[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      err_flag <= 1'b0;
      err_bits <= '0;
    end else begin
      r_v2     <= r_v1;
      err_flag <= r_v1 & (|w_ev);
      err_bits <= r_v1 ? w_pop : 7'd0;
    end
  end

  // Lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_run   <= '0;
      r_bad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_bad_nxt   = r_bad;
    if (r_v2) begin
      case (r_state)
        ST_HUNT: begin
          if (!err_flag) begin
            if (r_run == c_RUN_W'(LOCK_CNT - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = r_run + c_RUN_W'(1);
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (err_flag) begin
            if (r_bad == c_BAD_W'(UNLOCK_CNT - 1)) begin
              w_state_nxt = ST_HUNT;
              w_bad_nxt   = '0;
              w_run_nxt   = '0;
            end else begin
              w_bad_nxt = r_bad + c_BAD_W'(1);
            end
          end else begin
            w_bad_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = '0;
          w_bad_nxt   = '0;
        end
      endcase
    end
  end

  assign locked = (r_state == ST_LOCKED);

  // One extra bit catches the carry for saturation.
  assign w_err_sum = {1'b0, err_cnt} + (CNT_W+1)'(err_bits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else if (r_v2 && (r_state == ST_LOCKED)) begin
      err_cnt <= w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
      if (word_cnt != {48{1'b1}}) begin
        word_cnt <= word_cnt + 48'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs7_checker_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs7_checker_64
//  Purpose  : Randomised self-checking bench for prbs7_checker_64. A serial
//             bit-level reference model predicts per-word error counts, lock
//             behaviour and counters. A second instance with an 8-bit error
//             counter exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs7_checker_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic        en;
  logic        clr_cnt;

  logic        locked, err_flag;
  logic [6:0]  err_bits;
  logic [31:0] err_cnt;
  logic [47:0] word_cnt;

  logic        locked8, err_flag8;
  logic [6:0]  err_bits8;
  logic [7:0]  err_cnt8;
  logic [47:0] word_cnt8;

  always #5 clk = ~clk;

  prbs7_checker_64 u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_cnt(clr_cnt),
    .locked(locked), .err_flag(err_flag), .err_bits(err_bits),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  prbs7_checker_64 #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_cnt(clr_cnt),
    .locked(locked8), .err_flag(err_flag8), .err_bits(err_bits8),
    .err_cnt(err_cnt8), .word_cnt(word_cnt8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_prev;
  bit          m_primed;
  bit          p1_v, p2_v;
  int          p1_bits, p2_bits;
  bit          m_locked;
  int          m_run, m_bad;
  longint      m_err, m_err8, m_words;

  // Serial view: s[0..63] = previous word, s[64..127] = current word.
  // Every serial bit must equal s[t-7] ^ s[t-6].
  function automatic int word_errs(input logic [63:0] c, input logic [63:0] p);
    logic [127:0] s;
    int e;
    if (c == 64'd0) return 64;
    s = {c, p};
    e = 0;
    for (int t = 64; t < 128; t++) e += int'(s[t] ^ s[t-7] ^ s[t-6]);
    return e;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_primed = 0;
    p1_v = 0; p2_v = 0; p1_bits = 0; p2_bits = 0;
    m_locked = 0; m_run = 0; m_bad = 0;
    m_err = 0; m_err8 = 0; m_words = 0;
  endtask

  task automatic model_edge(input logic e, input logic [63:0] d, input logic c);
    if (p2_v) begin
      if (m_locked) begin
        m_err  = (m_err + p2_bits > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + p2_bits;
        m_err8 = (m_err8 + p2_bits > 255) ? 255 : m_err8 + p2_bits;
        m_words++;
        if (p2_bits != 0) begin
          m_bad++;
          if (m_bad == 4) begin m_locked = 0; m_bad = 0; m_run = 0; end
        end else m_bad = 0;
      end else begin
        if (p2_bits == 0) begin
          m_run++;
          if (m_run == 16) begin m_locked = 1; m_run = 0; end
        end else m_run = 0;
      end
    end
    if (c) begin m_err = 0; m_err8 = 0; m_words = 0; end
    p2_v = p1_v; p2_bits = p1_bits;
    p1_v = 0; p1_bits = 0;
    if (e) begin
      if (m_primed) begin p1_v = 1; p1_bits = word_errs(d, m_prev); end
      m_primed = 1;
      m_prev   = d;
    end
  endtask

  task automatic compare_all();
    int eb;
    eb = p2_v ? p2_bits : 0;
    chk("locked",    locked,    m_locked);
    chk("err_flag",  err_flag,  eb != 0);
    chk("err_bits",  err_bits,  eb);
    chk("err_cnt",   err_cnt,   m_err);
    chk("word_cnt",  word_cnt,  m_words);
    chk("locked8",   locked8,   m_locked);
    chk("err_flag8", err_flag8, eb != 0);
    chk("err_bits8", err_bits8, eb);
    chk("err_cnt8",  err_cnt8,  m_err8);
    chk("word_cnt8", word_cnt8, m_words);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] h = 7'h7F;   // last seven serial bits, h[0] oldest

  task automatic gen(output logic [63:0] w);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b    = h[0] ^ h[1];
      w[i] = b;
      h    = {b, h[6:1]};
    end
  endtask

  task automatic step(input logic e, input logic [63:0] d, input logic c);
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    model_edge(e, d, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] flip, input logic c);
    logic [63:0] w;
    gen(w);
    step(1'b1, w ^ flip, c);
  endtask

  task automatic idle();
    step(1'b0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_locked",   locked,   0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_bits", err_bits, 0);
    chk("rst_err_cnt",  err_cnt,  0);
    chk("rst_word_cnt", word_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] m;
    model_reset();
    rst_n = 1'b0; en = 1'b0; din = '0; clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Lock timing: prime word + 16 checked words, lock two edges later.
    clean(18);
    chk("lock_before", locked, 0);
    clean(1);
    chk("lock_after", locked, 1);
    clean(5);

    // Single flip at bit 10 -> errors at 10, 16, 17.
    send(64'd1 << 10, 1'b0);
    clean(1);
    chk("flip10_bits", err_bits, 3);
    clean(3);
    chk("flip10_cnt", err_cnt, 3);

    // Flip at bit 60 -> 1 error now, 2 in next word (bits 2 and 3).
    send(64'd1 << 60, 1'b0);
    clean(1);
    chk("flip60_bits", err_bits, 1);
    clean(1);
    chk("flip60_next", err_bits, 2);
    clean(4);

    // Four all-zero words unlock; a fifth is not counted.
    send('0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 64'd0, 1'b0);
    clean(25);

    // Random mix of qualifiers, sparse single-bit errors, occasional clear.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) idle();
      else begin
        m = ($urandom_range(0, 15) == 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
        send(m, $urandom_range(0, 49) == 0);
      end
    end

    // Alternate 9-error and clean words while locked to saturate the 8-bit count.
    clean(22);
    m = (64'd1 << 10) | (64'd1 << 30) | (64'd1 << 50);
    for (int i = 0; i < 32; i++) begin
      send(m, 1'b0);
      clean(1);
    end
    chk("sat8", err_cnt8, 255);

    // Clear on the same edge that would count an errored word.
    send(m, 1'b0);
    clean(1);
    send('0, 1'b1);
    chk("clr_err", err_cnt, 0);
    chk("clr_words", word_cnt, 0);
    clean(3);

    // en toggling every cycle, then reset mid-stream and relock.
    for (int i = 0; i < 40; i++) begin
      send('0, 1'b0);
      idle();
    end
    pulse_reset();
    clean(25);
    chk("relock", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/prbs7_checker_64.md
Name: prbs7_checker_64

Overview:
- Consumes the 64-bit aligned word stream from the byte shifter stage and checks it against a PRBS-7 sequence (x^7+x^6+1).
- The checker is self-synchronising: each bit is predicted from earlier received bits, so no seed alignment is required.
- Provides a lock state machine, a per-word error flag and saturating bit-error and word counters for link BER measurement on the KC705 SERDES path.

Parameters:
- LOCK_CNT, 16: consecutive error-free words required to go from HUNT to LOCKED.
- UNLOCK_CNT, 4: consecutive errored words required to go from LOCKED to HUNT.
- CNT_W, 32: width of err_cnt.

Ports:
- clk  in  1  word clock, same as the shifter output clock
- rst_n  in  1  reset; asynchronous assert, active-low
- din  in  64  aligned data word; bit 0 = earliest serial bit
- en  in  1  word qualifier; 0 = word ignored
- clr_cnt  in  1  synchronous clear of err_cnt and word_cnt
- locked  out  1  1 while the FSM is in LOCKED
- err_flag  out  1  current checked word contained at least 1 bit error
- err_bits  out  7  popcount of the error vector of the current checked word (0..64)
- err_cnt  out  CNT_W  saturating bit-error total, counted only while LOCKED
- word_cnt  out  48  saturating count of words checked while LOCKED

Behaviour:
- Reset: all outputs 0; FSM = HUNT; primed = 0; internal prev word = 0; pipelines cleared. Reset mid-operation aborts everything immediately.
- Prediction, with c = current word and p = previous accepted word:
  - Bits n = 7..63: pred[n] = c[n-7] ^ c[n-6].
  - Bits 0..5: pred[n] = p[n+57] ^ p[n+58].
  - Bit 6: pred[6] = p[63] ^ c[0].
  - ev = c ^ pred.
- All-zero word: c == 0 forces ev = all ones (64 errors). This makes lock-up on a dead link impossible.
- Pipeline (word accepted at edge k when en=1):
  - Edge k: c and p registered.
  - Edge k+1: ev registered; err_flag = |ev and err_bits = popcount(ev) are valid after k+1.
  - Edge k+2: counters and FSM update from the k+1 values.
- en = 0: the word is not registered, p is unchanged, and no counter or FSM update occurs for that slot. err_flag and err_bits drop to 0 one cycle later.
- Priming: the first accepted word after reset only loads p (primed := 1). It produces no check result; err_flag, err_bits and counters are untouched.
- FSM:
  - HUNT: run counter counts consecutive clean words and resets to 0 on an errored word. At run == LOCK_CNT, go to LOCKED and clear the run counter. locked rises after edge k+2 of the LOCK_CNT-th clean word.
  - LOCKED: bad counter counts consecutive errored words and resets to 0 on a clean word. At bad == UNLOCK_CNT, go to HUNT and clear the counters.
- Counting: only while the FSM is LOCKED before the update edge.
  - err_cnt += err_bits, saturating at 2^CNT_W-1.
  - word_cnt += 1, saturating at 2^48-1.
  - The word that causes LOCKED->HUNT is still counted. Words checked in HUNT are never counted.
- clr_cnt: takes priority over a simultaneous increment; both counters read 0 after the edge. The FSM is unaffected.

Test Plan:
- Clean PRBS-7 stream (seed 7'h7F), en=1 continuous -> locked rises on cycle 1+16+2 after the first word; err_cnt stays 0; word_cnt increments by 1 per cycle.
- Locked, then flip din bit 10 in one word -> err_bits=3 for that word (bits 10, 16, 17); err_cnt=3; locked stays 1.
- Locked, then flip bit 60 -> err_bits=1 for that word, then err_bits=2 for the next word (bits 2 and 3); err_cnt=3.
- Locked, then 4 all-zero words -> err_bits=64 each; locked falls after the 4th; err_cnt=256; a 5th zero word is not counted.
- Locked with err_cnt preloaded near 2^32-1 via a long error run -> err_cnt holds at 32'hFFFFFFFF; clr_cnt in the same cycle as an error -> counters read 0.
- en toggling 1/0 every cycle on a clean stream -> same lock after 16 accepted words with no errors; rst_n pulsed low mid-stream -> outputs 0 asynchronously, re-prime and re-lock.
